// File: rtl/ifu_pkg.sv
// ifu_pkg: opcodes, sequencer states and error codes shared by the fetch unit
package ifu_pkg;

  localparam logic [2:0] OP_MV  = 3'b000;
  localparam logic [2:0] OP_MVI = 3'b001;
  localparam logic [2:0] OP_ADD = 3'b010;
  localparam logic [2:0] OP_SUB = 3'b011;

  typedef enum logic [2:0] {
    IDLE,
    FETCH_OP,
    WAIT_OP,
    FETCH_IMM,
    WAIT_IMM,
    ISSUE,
    WAIT_DONE,
    ERR
  } ifu_state_t;

  localparam logic [1:0] ERR_NONE    = 2'b00;
  localparam logic [1:0] ERR_ILLEGAL = 2'b01;
  localparam logic [1:0] ERR_TIMEOUT = 2'b10;

  function automatic logic is_legal(input logic [2:0] op);
    return op inside {OP_MV, OP_MVI, OP_ADD, OP_SUB};
  endfunction

endpackage

// File: rtl/instr_fetch_unit_done_watchdog.sv
// done_watchdog: counts cycles spent waiting for Done and flags the last allowed cycle
module done_watchdog #(
  parameter int DONE_TIMEOUT = 16
) (
  input  logic clk,
  input  logic Resetn,
  input  logic clear,
  input  logic en,
  output logic expired
);

  localparam int W = $clog2(DONE_TIMEOUT + 1);

  logic [W-1:0] r_cnt;

  assign expired = en && (r_cnt == W'(DONE_TIMEOUT - 1));

  // cycle counter: cleared outside the wait, saturates once the limit is reached
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn)
      r_cnt <= '0;
    else if (clear)
      r_cnt <= '0;
    else if (en && !expired)
      r_cnt <= r_cnt + 1'b1;
  end

endmodule

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit: fetches instructions from a synchronous ROM and hands them to the control unit
module instr_fetch_unit
  import ifu_pkg::*;
#(
  parameter int ADDR_W       = 5,
  parameter int DATA_W       = 9,
  parameter int DONE_TIMEOUT = 16,
  parameter int CNT_W        = 8
) (
  input  logic              clk,
  input  logic              Resetn,
  input  logic              start,
  input  logic [ADDR_W-1:0] start_addr,
  input  logic              stop,
  output logic [ADDR_W-1:0] mem_addr,
  output logic              mem_rd,
  input  logic [DATA_W-1:0] mem_data,
  output logic [8:0]        IR,
  output logic [DATA_W-1:0] DIN,
  output logic              Run,
  input  logic              Done,
  output logic [ADDR_W-1:0] pc,
  output logic              busy,
  output logic              err,
  output logic [1:0]        err_code,
  output logic [CNT_W-1:0]  instr_count
);

  ifu_state_t        r_state;
  ifu_state_t        w_next;
  logic [ADDR_W-1:0] r_pc;
  logic [8:0]        r_ir;
  logic [DATA_W-1:0] r_din;
  logic [1:0]        r_err_code;
  logic [CNT_W-1:0]  r_cnt;
  logic              w_in_wait;
  logic              w_expired;
  logic              w_fetch;
  logic              w_accept;
  logic [2:0]        w_opcode;
  logic              w_legal;

  assign w_in_wait = r_state == WAIT_DONE;
  assign w_fetch   = r_state == FETCH_OP || r_state == FETCH_IMM;
  assign w_accept  = (r_state == IDLE || r_state == ERR) && start;
  assign w_opcode  = mem_data[8:6];
  assign w_legal   = is_legal(w_opcode);

  assign mem_rd      = w_fetch;
  assign mem_addr    = w_fetch ? r_pc : '0;
  assign Run         = r_state == ISSUE;
  assign busy        = r_state != IDLE && r_state != ERR;
  assign err         = r_state == ERR;
  assign err_code    = r_err_code;
  assign IR          = r_ir;
  assign DIN         = r_din;
  assign pc          = r_pc;
  assign instr_count = r_cnt;

  done_watchdog #(
    .DONE_TIMEOUT(DONE_TIMEOUT)
  ) u_watchdog (
    .clk    (clk),
    .Resetn (Resetn),
    .clear  (!w_in_wait),
    .en     (w_in_wait),
    .expired(w_expired)
  );

  // state register
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn)
      r_state <= IDLE;
    else
      r_state <= w_next;
  end

  // next state: Done beats a simultaneous timeout, stop only matters when Done arrives
  always_comb begin
    w_next = r_state;
    case (r_state)
      IDLE, ERR: w_next = start ? FETCH_OP : r_state;
      FETCH_OP:  w_next = WAIT_OP;
      WAIT_OP:   w_next = !w_legal ? ERR : (w_opcode == OP_MVI ? FETCH_IMM : ISSUE);
      FETCH_IMM: w_next = WAIT_IMM;
      WAIT_IMM:  w_next = ISSUE;
      ISSUE:     w_next = WAIT_DONE;
      WAIT_DONE: w_next = Done ? (stop ? IDLE : FETCH_OP) : (w_expired ? ERR : WAIT_DONE);
      default:   w_next = IDLE;
    endcase
  end

  // datapath: pc, instruction/immediate capture, error code and retire counter
  always_ff @(posedge clk or negedge Resetn) begin
    if (!Resetn) begin
      r_pc       <= '0;
      r_ir       <= '0;
      r_din      <= '0;
      r_err_code <= ERR_NONE;
      r_cnt      <= '0;
    end else begin
      if (w_accept) begin
        r_pc       <= start_addr;
        r_err_code <= ERR_NONE;
      end
      if (r_state == WAIT_OP) begin
        r_ir <= mem_data[8:0];
        r_pc <= r_pc + 1'b1;
        if (!w_legal)
          r_err_code <= ERR_ILLEGAL;
      end
      if (r_state == WAIT_IMM) begin
        r_din <= mem_data;
        r_pc  <= r_pc + 1'b1;
      end
      if (w_in_wait && Done)
        r_cnt <= r_cnt + 1'b1;
      if (w_in_wait && !Done && w_expired)
        r_err_code <= ERR_TIMEOUT;
    end
  end

endmodule

// File: tb/tb_instr_fetch_unit.sv
// tb_instr_fetch_unit: randomized episodes checked every cycle against a schedule-level model
module tb_instr_fetch_unit;

  logic       clk = 1'b0;
  logic       Resetn;
  logic       start;
  logic [4:0] start_addr;
  logic       stop;
  logic [4:0] mem_addr;
  logic       mem_rd;
  logic [8:0] mem_data = '0;
  logic [8:0] IR;
  logic [8:0] DIN;
  logic       Run;
  logic       Done;
  logic [4:0] pc;
  logic       busy;
  logic       err;
  logic [1:0] err_code;
  logic [7:0] instr_count;

  instr_fetch_unit dut (
    .clk(clk), .Resetn(Resetn), .start(start), .start_addr(start_addr), .stop(stop),
    .mem_addr(mem_addr), .mem_rd(mem_rd), .mem_data(mem_data), .IR(IR), .DIN(DIN),
    .Run(Run), .Done(Done), .pc(pc), .busy(busy), .err(err), .err_code(err_code),
    .instr_count(instr_count)
  );

  always #5 clk = ~clk;

  logic [8:0] rom [0:31];
  always @(posedge clk) if (mem_rd) mem_data <= rom[mem_addr];

  typedef struct packed {
    logic       start;
    logic [4:0] sa;
    logic       stop;
    logic       done;
  } stim_t;

  typedef struct packed {
    logic       rd;
    logic [4:0] addr;
    logic       run;
    logic       busy;
    logic       err;
    logic [1:0] code;
    logic [4:0] pc;
    logic [8:0] ir;
    logic [8:0] din;
    logic [7:0] cnt;
  } exp_t;

  stim_t stim_q [$];
  exp_t  plan_q [$];
  exp_t  exp_q  [$];
  exp_t  e;
  stim_t s;

  int checks = 0;
  int errors = 0;

  logic [4:0] m_pc;
  logic [8:0] m_ir;
  logic [8:0] m_din;
  logic [7:0] m_cnt;
  logic [1:0] m_code;
  logic       m_err;

  int  lat = 0;
  int  lat_cnt = 0;
  bit  lat_arm = 0;
  int  run_count = 0;
  int  rc_before;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s at %0t: got %0h want %0h", name, $time, got, want);
    end
  endtask

  function automatic logic rb();
    return 1'($urandom_range(0, 1));
  endfunction

  // every cycle with a planned expectation is compared field by field
  always @(negedge clk) begin
    if (exp_q.size() != 0) begin
      e = exp_q.pop_front();
      chk("mem_rd", mem_rd, e.rd);
      if (e.rd) chk("mem_addr", mem_addr, e.addr);
      chk("Run", Run, e.run);
      chk("busy", busy, e.busy);
      chk("err", err, e.err);
      chk("err_code", err_code, e.code);
      chk("pc", pc, e.pc);
      chk("IR", IR, e.ir);
      chk("DIN", DIN, e.din);
      chk("instr_count", instr_count, e.cnt);
    end
  end

  // observes cycles from an accepted start to the first Run, and counts Run pulses
  always @(negedge clk) begin
    if (Run) run_count++;
    if (Resetn && start && !busy) begin
      lat_cnt = 0;
      lat_arm = 1;
    end else if (lat_arm) begin
      lat_cnt++;
      if (Run) begin
        lat = lat_cnt;
        lat_arm = 0;
      end
    end
  end

  task automatic add(input logic rd, input logic [4:0] addr, input logic run, input logic bsy,
                     input logic done, input logic st, input logic [4:0] sa, input logic sp);
    stim_q.push_back('{st, sa, sp, done});
    plan_q.push_back('{rd, addr, run, bsy, m_err, m_code, m_pc, m_ir, m_din, m_cnt});
  endtask

  // plan one program run from a start pulse, then apply it cycle by cycle
  task automatic episode(input logic [4:0] sa, input int max_instr, input int fixed_d);
    int n;
    int d;
    bit fin;
    logic [8:0] w;
    stim_q.delete();
    plan_q.delete();
    add(1'b0, '0, 1'b0, 1'b0, rb(), 1'b1, sa, rb());
    m_pc = sa;
    m_code = 2'b00;
    m_err = 1'b0;
    n = 0;
    fin = 0;
    while (!fin) begin
      add(1'b1, m_pc, 1'b0, 1'b1, rb(), rb(), 5'($urandom), rb());
      add(1'b0, '0, 1'b0, 1'b1, rb(), rb(), 5'($urandom), rb());
      w = rom[m_pc];
      m_ir = w;
      m_pc = m_pc + 5'd1;
      if (w[8]) begin
        m_err = 1'b1;
        m_code = 2'b01;
        fin = 1;
      end else begin
        if (w[8:6] == 3'b001) begin
          add(1'b1, m_pc, 1'b0, 1'b1, rb(), rb(), 5'($urandom), rb());
          add(1'b0, '0, 1'b0, 1'b1, rb(), rb(), 5'($urandom), rb());
          m_din = rom[m_pc];
          m_pc = m_pc + 5'd1;
        end
        add(1'b0, '0, 1'b1, 1'b1, rb(), rb(), 5'($urandom), rb());
        d = fixed_d != 0 ? fixed_d : ($urandom_range(0, 19) == 0 ? 17 : int'($urandom_range(1, 16)));
        for (int k = 1; k <= 16 && k <= d; k++)
          add(1'b0, '0, 1'b0, 1'b1, k == d, rb(), 5'($urandom), (k == d) ? (n + 1 == max_instr) : rb());
        if (d > 16) begin
          m_err = 1'b1;
          m_code = 2'b10;
          fin = 1;
        end else begin
          m_cnt = m_cnt + 8'd1;
          n++;
          fin = n == max_instr;
        end
      end
    end
    for (int k = 0; k < 3; k++) add(1'b0, '0, 1'b0, 1'b0, rb(), 1'b0, 5'($urandom), rb());
    while (stim_q.size() != 0) begin
      s = stim_q.pop_front();
      start = s.start;
      start_addr = s.sa;
      stop = s.stop;
      Done = s.done;
      exp_q.push_back(plan_q.pop_front());
      @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_mem_addr"}, mem_addr, 0);
    chk({tag, "_mem_rd"}, mem_rd, 0);
    chk({tag, "_IR"}, IR, 0);
    chk({tag, "_DIN"}, DIN, 0);
    chk({tag, "_Run"}, Run, 0);
    chk({tag, "_pc"}, pc, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_err"}, err, 0);
    chk({tag, "_err_code"}, err_code, 0);
    chk({tag, "_instr_count"}, instr_count, 0);
  endtask

  initial begin
    for (int i = 0; i < 32; i++) rom[i] = 9'h000;
    Resetn = 1'b0;
    start = 1'b0;
    start_addr = '0;
    stop = 1'b0;
    Done = 1'b0;
    m_pc = '0; m_ir = '0; m_din = '0; m_cnt = '0; m_code = '0; m_err = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    Resetn = 1'b1;

    // mv R1,R2 at 3 followed by another mv at 4
    rom[3] = 9'b000_001_010;
    rom[4] = 9'b000_010_011;
    episode(5'd3, 2, 2);
    chk("t1_latency", lat, 3);
    chk("t1_IR", IR, 9'h013);
    chk("t1_pc", pc, 5);
    chk("t1_count", instr_count, 2);

    // mvi with immediate 0x155
    rom[0] = 9'b001_011_000;
    rom[1] = 9'h155;
    episode(5'd0, 1, 3);
    chk("t2_latency", lat, 5);
    chk("t2_IR", IR, 9'h058);
    chk("t2_DIN", DIN, 9'h155);
    chk("t2_pc", pc, 2);

    // illegal opcode, then recovery from ERR
    rom[5] = 9'b101_000_000;
    rc_before = run_count;
    episode(5'd5, 1, 2);
    chk("t3_err", err, 1);
    chk("t3_err_code", err_code, 2'b01);
    chk("t3_no_run", run_count - rc_before, 0);
    chk("t3_pc", pc, 6);
    episode(5'd0, 1, 1);
    chk("t3_recover_err", err, 0);
    chk("t3_recover_count", instr_count, 4);

    // Done timeout, then Done in the last allowed cycle
    rom[6] = 9'b010_000_001;
    episode(5'd6, 1, 17);
    chk("t4_err_code", err_code, 2'b10);
    episode(5'd6, 1, 16);
    chk("t4_late_done_err", err, 0);
    chk("t4_late_done_count", instr_count, 5);

    // immediate fetched across the pc wrap, stop after Done
    rom[31] = 9'b001_000_000;
    rom[0]  = 9'h0AA;
    episode(5'd31, 1, 2);
    chk("t5_DIN", DIN, 9'h0AA);
    chk("t5_pc", pc, 1);
    chk("t5_busy", busy, 0);
    chk("t5_latency", lat, 5);

    // asynchronous reset while waiting for an immediate
    rom[10] = 9'b001_100_000;
    rom[11] = 9'h123;
    start = 1'b1;
    start_addr = 5'd10;
    stop = 1'b0;
    Done = 1'b0;
    @(posedge clk);
    #1;
    start = 1'b0;
    repeat (3) begin
      @(posedge clk);
      #1;
    end
    chk("t6_busy_before", busy, 1);
    chk("t6_pc_before", pc, 11);
    #2 Resetn = 1'b0;
    #1 chk_all_zero("t6_async");
    @(posedge clk);
    #1 Resetn = 1'b1;
    m_pc = '0; m_ir = '0; m_din = '0; m_cnt = '0; m_code = '0; m_err = 1'b0;
    rc_before = run_count;
    repeat (6) begin
      @(negedge clk);
      chk("t6_idle_busy", busy, 0);
    end
    chk("t6_no_run", run_count - rc_before, 0);
    @(posedge clk);
    #1;

    // randomized programs
    for (int ep = 0; ep < 40; ep++) begin
      for (int i = 0; i < 32; i++)
        rom[i] = {($urandom_range(0, 9) == 0) ? 3'($urandom_range(4, 7)) : 3'($urandom_range(0, 3)),
                  6'($urandom)};
      episode(5'($urandom), int'($urandom_range(1, 6)), 0);
    end

    @(negedge clk);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
